div_unit: RTL
=============

DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clock `clock`, reset `reset`.
REQ-002 clock  in  1  rising-edge clock for all state.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 Start  in  1  single-cycle divide request from EX (DIV decoded); sampled only when accepting.
REQ-005 Dividend  in  32  signed dividend (Rs data), sampled with Start.
REQ-006 Divisor  in  32  signed divisor (Rt data), sampled with Start.
REQ-007 Stall  out  1  hold IF/ID/EX while a divide is in flight.
REQ-008 Done  out  1  one-cycle pulse; Hi/Lo valid from this cycle.
REQ-009 Hi  out  32  remainder register, read by MFHI.
REQ-010 Lo  out  32  quotient register.
REQ-011 DivByZero  out  1  last completed divide had Divisor == 0.

Function
REQ-012 FSM states SHALL be IDLE, RUN, FIX, DONE; exactly one active per cycle.
REQ-013 Start SHALL be accepted only in IDLE or DONE; a Start in RUN or FIX SHALL be ignored.
REQ-014 On acceptance, operands SHALL be latched as magnitudes, with dividend and divisor signs stored separately, and the iteration counter SHALL be loaded with 31.
REQ-015 An accepted Start with Divisor != 0 SHALL transition to RUN.
REQ-016 An accepted Start with Divisor == 0 SHALL transition directly to DONE, setting Hi = Dividend, Lo = 32'hFFFF_FFFF and DivByZero = 1.
REQ-017 RUN SHALL perform one restoring step per cycle:
  - shift {rem, quo} left by 1;
  - trial-subtract |Divisor| from the 33-bit remainder;
  - keep the difference and set quotient LSB to 1 if the difference is non-negative.
REQ-018 RUN SHALL last exactly 32 cycles, ending when the counter is 0, then go to FIX.
REQ-019 FIX SHALL apply sign correction as follows, load Hi/Lo, and go to DONE:
  - negate the quotient if the operand signs differ;
  - negate the remainder if the dividend is negative.
REQ-020 Latency SHALL be as follows, with Done high for exactly one cycle:
  - Start sampled at edge N -> Done high in the cycle after edge N+33 (34 cycles);
  - for a divide-by-zero -> Done high in the cycle after edge N.
REQ-021 DONE SHALL return to IDLE on the next edge unless a new Start is accepted there.
REQ-022 Stall SHALL be combinational: high when (Start && state in {IDLE, DONE} && Divisor != 0), or when state is RUN or FIX; low otherwise.
REQ-023 Hi, Lo and DivByZero SHALL change only on completion (FIX->DONE, or a divide-by-zero acceptance), and SHALL hold their values otherwise.
REQ-024 DivByZero SHALL be cleared on any completion with Divisor != 0.
REQ-025 -2^31 / -1 SHALL yield Lo = 32'h8000_0000, Hi = 0 (two's-complement wrap, no exception).
REQ-026 Magnitude of -2^31 SHALL be handled as unsigned 32'h8000_0000 without overflow.

Reset
REQ-027 When reset is high at a clock edge, the FSM SHALL go to IDLE, and Hi, Lo, the counter and the internal registers SHALL be set to 0.
REQ-028 When reset is high at a clock edge, Done and DivByZero SHALL be set to 0.
REQ-029 Reset SHALL take priority over Start.
REQ-030 Reset asserted during RUN or FIX SHALL abort the divide with no Done pulse, and Hi/Lo SHALL read 0.

Structure
REQ-031 A shared parameter header SHALL hold the following, for use by the control unit and the hazard logic:
  - the state encodings (2 bits);
  - DIV_WIDTH = 32;
  - DIV_ITERS = 32.
REQ-032 One combinational sub-module, div_step, SHALL implement a single restoring iteration. Inputs: rem[32:0], quo[31:0], divisor[31:0]. Outputs: next rem, next quo.
REQ-033 div_unit SHALL instantiate div_step once; it SHALL NOT be unrolled.

Verification
REQ-034 Reset: reset = 1 for 2 cycles -> Hi = 0, Lo = 0, Done = 0, Stall = 0, DivByZero = 0.
REQ-035 Basic divide: Start with 100 / 7 -> Stall high 34 cycles, Done in cycle 34, Lo = 14, Hi = 2.
REQ-036 Signs: -100 / 7 -> Lo = -14 (32'hFFFF_FFF2), Hi = -2. 100 / -7 -> Lo = -14, Hi = 2.
REQ-037 Divide by zero: 55 / 0 -> Done the next cycle, Stall low, Hi = 55, Lo = 32'hFFFF_FFFF, DivByZero = 1. A following 9 / 3 -> DivByZero = 0, Lo = 3, Hi = 0.
REQ-038 Overflow edge: 32'h8000_0000 / -1 -> Lo = 32'h8000_0000, Hi = 0.
REQ-039 Abort and busy-Start:
  - Start (1000 / 10) at cycle 0, Start (5 / 5) at cycle 10 -> second Start ignored, Lo = 100.
  - reset at cycle 20 of a new divide -> no Done pulse, Hi = Lo = 0.

Source files
------------

// File: rtl/div_unit_pkg.sv
// Shared definitions for the iterative divider: FSM encoding, datapath widths
// and the magnitude helper used when operands are latched.
package div_unit_pkg;

    localparam int DIV_WIDTH = 32;
    localparam int DIV_ITERS = 32;
    localparam int CNT_WIDTH = $clog2(DIV_ITERS);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_FIX  = 2'b10,
        ST_DONE = 2'b11
    } div_state_t;

    // -2^31 maps onto itself, which is exactly 2^31 when read back as unsigned.
    function automatic logic [DIV_WIDTH-1:0] magnitude(input logic [DIV_WIDTH-1:0] v);
        return v[DIV_WIDTH-1] ? -v : v;
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift {rem, quo} left, trial-subtract the
// divisor magnitude, and keep the difference when it does not go negative.
module div_step
    import div_unit_pkg::*;
(
    input  logic [DIV_WIDTH:0]   rem,
    input  logic [DIV_WIDTH-1:0] quo,
    input  logic [DIV_WIDTH-1:0] divisor,
    output logic [DIV_WIDTH:0]   rem_next,
    output logic [DIV_WIDTH-1:0] quo_next
);

    // One extra bit above the shifted remainder holds the borrow of the trial subtract.
    logic [DIV_WIDTH+1:0] rem_shift;
    logic [DIV_WIDTH+1:0] diff;

    // NOTE: every output gets a default before the if, otherwise a latch is inferred.
    always_comb begin
        rem_shift = {rem, quo[DIV_WIDTH-1]};
        diff      = rem_shift - {2'b00, divisor};
        rem_next  = rem_shift[DIV_WIDTH:0];
        quo_next  = {quo[DIV_WIDTH-2:0], 1'b0};
        if (!diff[DIV_WIDTH+1]) begin
            rem_next    = diff[DIV_WIDTH:0];
            quo_next[0] = 1'b1;
        end
    end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle signed 32-bit divider: one restoring step per cycle on operand
// magnitudes, then a sign-fix cycle before Hi (remainder) / Lo (quotient) load.
module div_unit
    import div_unit_pkg::*;
(
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 Start,
    input  logic [DIV_WIDTH-1:0] Dividend,
    input  logic [DIV_WIDTH-1:0] Divisor,
    output logic                 Stall,
    output logic                 Done,
    output logic [DIV_WIDTH-1:0] Hi,
    output logic [DIV_WIDTH-1:0] Lo,
    output logic                 DivByZero
);

    div_state_t           state_q;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic [DIV_WIDTH:0]   rem_q;
    logic [DIV_WIDTH-1:0] quo_q;
    logic [DIV_WIDTH-1:0] dsr_q;
    logic                 dvd_neg_q;
    logic                 dsr_neg_q;

    logic [DIV_WIDTH:0]   rem_next;
    logic [DIV_WIDTH-1:0] quo_next;
    logic                 accepting;

    div_step u_step (
        .rem      (rem_q),
        .quo      (quo_q),
        .divisor  (dsr_q),
        .rem_next (rem_next),
        .quo_next (quo_next)
    );

    assign accepting = (state_q == ST_IDLE) || (state_q == ST_DONE);

    // A divide-by-zero completes on the accepting edge, so it never stalls the pipe.
    assign Stall = (Start && accepting && (Divisor != '0))
                || (state_q == ST_RUN) || (state_q == ST_FIX);

    // NOTE: all state here is updated with non-blocking assignments so every
    // register samples pre-edge values, matching the hardware it describes.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dsr_q     <= '0;
            dvd_neg_q <= 1'b0;
            dsr_neg_q <= 1'b0;
            Hi        <= '0;
            Lo        <= '0;
            Done      <= 1'b0;
            DivByZero <= 1'b0;
        end else begin
            Done <= 1'b0;
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (Start) begin
                        dvd_neg_q <= Dividend[DIV_WIDTH-1];
                        dsr_neg_q <= Divisor[DIV_WIDTH-1];
                        rem_q     <= '0;
                        quo_q     <= magnitude(Dividend);
                        dsr_q     <= magnitude(Divisor);
                        cnt_q     <= CNT_WIDTH'(DIV_ITERS - 1);
                        if (Divisor == '0) begin
                            Hi        <= Dividend;
                            Lo        <= '1;
                            DivByZero <= 1'b1;
                            Done      <= 1'b1;
                            state_q   <= ST_DONE;
                        end else begin
                            state_q <= ST_RUN;
                        end
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    rem_q <= rem_next;
                    quo_q <= quo_next;
                    if (cnt_q == '0) begin
                        state_q <= ST_FIX;
                    end else begin
                        cnt_q <= cnt_q - CNT_WIDTH'(1);
                    end
                end
                ST_FIX: begin
                    // Quotient sign is the XOR of operand signs; remainder follows the dividend.
                    Lo        <= (dvd_neg_q ^ dsr_neg_q) ? -quo_q : quo_q;
                    Hi        <= dvd_neg_q ? -rem_q[DIV_WIDTH-1:0] : rem_q[DIV_WIDTH-1:0];
                    DivByZero <= 1'b0;
                    Done      <= 1'b1;
                    state_q   <= ST_DONE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule
